canvas_port_arbiter: RTL and testbench
======================================

Name: canvas_port_arbiter

Overview:
Owns the single read/write port "a" of the small_canvas distributed RAM.
Shares that port between three users:
- mouse_input, which writes strokes;
- recognizer, which reads the bitmap during a recognition session;
- an internal clear engine, which sweeps the canvas to blank after a recognition result is committed.

It replaces the ad-hoc address mux and write gating in top with a state machine that gives explicit grants and drops conflicting writes in a defined way.

Parameters:
- ADDR_W, 10, canvas address width.
- DEPTH, 1024, number of canvas cells swept by a clear (must be ≤ 2^ADDR_W).
- CLEAR_VALUE, 1'b0, bit written to every cell during a clear.
- DROP_W, 8, width of the saturating dropped-write counter.

Ports:
- clk  in  1  system clock (100 MHz domain)
- rst  in  1  asynchronous, active-high reset
- mouse_we  in  1  mouse write request, valid in the same cycle
- mouse_addr  in  ADDR_W  mouse write address
- mouse_data  in  1  mouse write pixel
- mouse_grant  out  1  high while mouse writes are accepted (combinational, equals state==IDLE)
- rec_req  in  1  recognizer session request, level; held for the whole read session
- rec_addr  in  ADDR_W  recognizer read address
- rec_grant  out  1  high while the recognizer owns the port (state==READ)
- rec_rdata  out  1  read data returned to the recognizer, equals ram_spo
- clear_req  in  1  single-cycle pulse requesting a canvas clear
- ram_a  out  ADDR_W  address driven to small_canvas port a
- ram_d  out  1  write data to small_canvas
- ram_we  out  1  write enable to small_canvas
- ram_spo  in  1  asynchronous read data from small_canvas port a
- busy  out  1  high in READ or CLEAR, or while a clear is pending
- clear_done  out  1  single-cycle pulse after the last clear write
- dropped_writes  out  DROP_W  count of mouse writes rejected; saturates at all-ones

Behaviour:
- States: IDLE, READ, CLEAR. Reset asynchronously forces:
  - state=IDLE, clr_cnt=0, clear_pending=0, clear_done=0, dropped_writes=0.
- Port mux (combinational):
  - IDLE: ram_a=mouse_addr, ram_d=mouse_data, ram_we=mouse_we.
  - READ: ram_a=rec_addr, ram_d=0, ram_we=0.
  - CLEAR: ram_a=clr_cnt, ram_d=CLEAR_VALUE, ram_we=1.
- rec_rdata=ram_spo at all times. It is meaningful only while rec_grant=1.
- IDLE transitions, evaluated on each rising edge, in priority order:
  1. (clear_req | clear_pending) -> CLEAR; clr_cnt<=0; clear_pending<=0.
  2. Else rec_req -> READ.
  3. Else stay in IDLE.
- The mouse write in the cycle that leaves IDLE is still committed, because the mux is in IDLE during that cycle.
- READ:
  - Stays while rec_req=1.
  - rec_req=0 -> IDLE, or straight to CLEAR if clear_pending=1, with clr_cnt<=0 and clear_pending<=0.
  - clear_req in READ sets clear_pending and does not abort the session.
- CLEAR:
  - One write per cycle; clr_cnt increments each cycle.
  - When clr_cnt==DEPTH-1 the write occurs, then state->IDLE and clear_done=1 for exactly one cycle.
  - Total duration is DEPTH cycles.
  - clear_req during CLEAR is absorbed and does not restart or extend the sweep.
  - rec_req during CLEAR waits. READ is entered from IDLE after completion, so there is one IDLE cycle between CLEAR and READ.
- Simultaneous clear_req and rec_req in IDLE: clear wins; the recognizer is granted after the clear finishes.
- Dropped writes: mouse_we=1 while state!=IDLE increments dropped_writes by 1, saturating at 2^DROP_W-1. No RAM write occurs for that cycle.
- busy = (state!=IDLE) | clear_pending.
- rst asserted mid-CLEAR or mid-READ: all state returns to reset values immediately.
  - The canvas is left partially cleared; no clear_done is produced.
  - ram_we drops to mouse_we as soon as the state is IDLE.
- clr_cnt width is ADDR_W. It never wraps, because the terminal count is DEPTH-1.

Test Plan:
1. Reset, then mouse_we=1, addr=37, data=1 in IDLE -> ram_we=1, ram_a=37, ram_d=1 in the same cycle; mouse_grant=1; dropped_writes=0.
2. clear_req pulse in IDLE -> from the next cycle, ram_we=1 with ram_a=0..1023 over 1024 consecutive cycles and ram_d=0. Then clear_done is high for 1 cycle and state is IDLE. A second clear_req at cycle 500 changes nothing.
3. rec_req held for 1024 cycles with rec_addr sweeping -> rec_grant=1 from the cycle after the request, ram_we=0 throughout, rec_rdata tracks the model RAM. Ten mouse_we pulses during the session -> dropped_writes=10.
4. clear_req during an active READ -> busy=1, the session is uninterrupted. rec_req falls -> CLEAR starts on the next edge, ram_a=0. clear_done occurs 1024 cycles later.
5. clear_req and rec_req asserted in the same IDLE cycle -> CLEAR first. After clear_done, one IDLE cycle, then READ with rec_grant=1.
6. Assert rst at CLEAR cycle 300 -> state IDLE, clr_cnt=0, busy=0, no clear_done. Cells 300..1023 keep their old values. Also: 300 dropped writes with DROP_W=8 -> dropped_writes saturates at 255.

Source files
------------

// File: rtl/canvas_port_arbiter_if.sv
// Bundles the mouse, recognizer and small_canvas port-a signals shared by canvas_port_arbiter.
// slave is the arbiter side; master is the side that drives requests and models the RAM.
interface canvas_port_arbiter_if #(
    parameter int ADDR_W = 10
);
    logic              mouse_we;
    logic [ADDR_W-1:0] mouse_addr;
    logic              mouse_data;
    logic              mouse_grant;
    logic              rec_req;
    logic [ADDR_W-1:0] rec_addr;
    logic              rec_grant;
    logic              rec_rdata;
    logic [ADDR_W-1:0] ram_a;
    logic              ram_d;
    logic              ram_we;
    logic              ram_spo;

    modport slave (
        input  mouse_we, mouse_addr, mouse_data, rec_req, rec_addr, ram_spo,
        output mouse_grant, rec_grant, rec_rdata, ram_a, ram_d, ram_we
    );

    modport master (
        output mouse_we, mouse_addr, mouse_data, rec_req, rec_addr, ram_spo,
        input  mouse_grant, rec_grant, rec_rdata, ram_a, ram_d, ram_we
    );
endinterface

// File: rtl/canvas_port_arbiter.sv
// Shares small_canvas port a between mouse writes, recognizer reads and a clear sweep.
// Mouse writes that arrive while another user owns the port are dropped and counted.
module canvas_port_arbiter #(
    parameter int   ADDR_W      = 10,
    parameter int   DEPTH       = 1024,
    parameter logic CLEAR_VALUE = 1'b0,
    parameter int   DROP_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    canvas_port_arbiter_if.slave  bus,
    input  logic                  clear_req,
    output logic                  busy,
    output logic                  clear_done,
    output logic [DROP_W-1:0]     dropped_writes
);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, READ, CLEAR} state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] clr_cnt;
    logic              clear_pending;
    logic              start_clear;

    always_comb begin
        state_next  = state;
        start_clear = 1'b0;
        bus.ram_a   = bus.mouse_addr;
        bus.ram_d   = bus.mouse_data;
        bus.ram_we  = bus.mouse_we;
        case (state)
            IDLE: begin
                if (clear_req || clear_pending) begin
                    state_next  = CLEAR;
                    start_clear = 1'b1;
                end else if (bus.rec_req) begin
                    state_next = READ;
                end
            end
            READ: begin
                bus.ram_a  = bus.rec_addr;
                bus.ram_d  = 1'b0;
                bus.ram_we = 1'b0;
                if (!bus.rec_req) begin
                    if (clear_pending) begin
                        state_next  = CLEAR;
                        start_clear = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            CLEAR: begin
                bus.ram_a  = clr_cnt;
                bus.ram_d  = CLEAR_VALUE;
                bus.ram_we = 1'b1;
                if (clr_cnt == LAST) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.mouse_grant = (state == IDLE);
    assign bus.rec_grant   = (state == READ);
    assign bus.rec_rdata   = bus.ram_spo;
    assign busy            = (state != IDLE) || clear_pending;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            clr_cnt        <= '0;
            clear_pending  <= 1'b0;
            clear_done     <= 1'b0;
            dropped_writes <= '0;
        end else begin
            state      <= state_next;
            clear_done <= (state == CLEAR) && (clr_cnt == LAST);
            // Starting a sweep consumes any pending request, including one arriving that cycle.
            if (start_clear) begin
                clr_cnt       <= '0;
                clear_pending <= 1'b0;
            end else begin
                if (state == CLEAR && clr_cnt != LAST) clr_cnt <= clr_cnt + 1'b1;
                if (state == READ && clear_req) clear_pending <= 1'b1;
            end
            if (bus.mouse_we && state != IDLE && dropped_writes != '1)
                dropped_writes <= dropped_writes + 1'b1;
        end
    end
endmodule

// File: tb/tb_canvas_port_arbiter.sv
// Randomized bench for canvas_port_arbiter against a cycle-level behavioural model of the
// port ownership rules, with a behavioural small_canvas RAM attached to port a.
module tb_canvas_port_arbiter;
    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1024;
    localparam int DROP_W = 8;
    localparam int DROP_MAX = (1 << DROP_W) - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              clear_req = 1'b0;
    logic              busy;
    logic              clear_done;
    logic [DROP_W-1:0] dropped_writes;

    canvas_port_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

    canvas_port_arbiter #(
        .ADDR_W(ADDR_W), .DEPTH(DEPTH), .CLEAR_VALUE(1'b0), .DROP_W(DROP_W)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus), .clear_req(clear_req),
        .busy(busy), .clear_done(clear_done), .dropped_writes(dropped_writes)
    );

    always #5 clk = ~clk;

    // Behavioural small_canvas: async read, sync write.
    logic mem [DEPTH];
    assign bus.ram_spo = mem[bus.ram_a];
    always @(posedge clk) if (bus.ram_we) mem[bus.ram_a] <= bus.ram_d;

    // Reference model: who owns the port, how much sweep remains, and the expected canvas.
    bit m_reading;
    int m_sweep_left;
    bit m_pending;
    bit m_done;
    int m_drops;
    bit ref_canvas [DEPTH];

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        m_reading    = 1'b0;
        m_sweep_left = 0;
        m_pending    = 1'b0;
        m_done       = 1'b0;
        m_drops      = 0;
    endtask

    task automatic compare_outputs();
        bit idle;
        logic [31:0] ea, ed, ewe;
        idle = !m_reading && m_sweep_left == 0;
        if (m_sweep_left > 0) begin
            ea = 32'(DEPTH - m_sweep_left); ed = 0; ewe = 1;
        end else if (m_reading) begin
            ea = 32'(bus.rec_addr); ed = 0; ewe = 0;
        end else begin
            ea = 32'(bus.mouse_addr); ed = 32'(bus.mouse_data); ewe = 32'(bus.mouse_we);
        end
        check("ram_a", 32'(bus.ram_a), ea);
        check("ram_d", 32'(bus.ram_d), ed);
        check("ram_we", 32'(bus.ram_we), ewe);
        check("mouse_grant", 32'(bus.mouse_grant), 32'(idle));
        check("rec_grant", 32'(bus.rec_grant), 32'(m_reading));
        check("busy", 32'(busy), 32'(!idle || m_pending));
        check("clear_done", 32'(clear_done), 32'(m_done));
        check("dropped", 32'(dropped_writes), 32'((m_drops > DROP_MAX) ? DROP_MAX : m_drops));
        if (m_reading) check("rec_rdata", 32'(bus.rec_rdata), 32'(mem[bus.rec_addr]));
    endtask

    task automatic model_update();
        bit old_pending;
        m_done = 1'b0;
        if (rst) begin
            model_reset();
        end else if (m_sweep_left > 0) begin
            if (bus.mouse_we) m_drops++;
            ref_canvas[DEPTH - m_sweep_left] = 1'b0;
            m_sweep_left--;
            if (m_sweep_left == 0) m_done = 1'b1;
        end else if (m_reading) begin
            if (bus.mouse_we) m_drops++;
            old_pending = m_pending;
            if (clear_req) m_pending = 1'b1;
            if (!bus.rec_req) begin
                m_reading = 1'b0;
                if (old_pending) begin
                    m_sweep_left = DEPTH;
                    m_pending    = 1'b0;
                end
            end
        end else begin
            if (bus.mouse_we) ref_canvas[bus.mouse_addr] = bus.mouse_data;
            if (clear_req || m_pending) begin
                m_sweep_left = DEPTH;
                m_pending    = 1'b0;
            end else if (bus.rec_req) begin
                m_reading = 1'b1;
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        compare_outputs();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic rand_mouse();
        bus.mouse_we   = 1'($urandom_range(0, 1));
        bus.mouse_addr = ADDR_W'($urandom);
        bus.mouse_data = 1'($urandom);
    endtask

    task automatic check_canvas(input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_canvas[i]) bad++;
        check(tag, 32'(bad), 32'd0);
    endtask

    initial begin
        int drop_pulses;
        for (int i = 0; i < DEPTH; i++) begin
            mem[i]        = 1'($urandom);
            ref_canvas[i] = mem[i];
        end
        bus.mouse_we = 0; bus.mouse_addr = '0; bus.mouse_data = 0;
        bus.rec_req = 0; bus.rec_addr = '0;
        model_reset();
        step();
        step();
        rst = 1'b0;
        step();

        // Mouse write passes straight through in IDLE.
        bus.mouse_we = 1; bus.mouse_addr = 10'd37; bus.mouse_data = 1;
        #1;
        check("t1_we", 32'(bus.ram_we), 32'd1);
        check("t1_a", 32'(bus.ram_a), 32'd37);
        check("t1_grant", 32'(bus.mouse_grant), 32'd1);
        step();
        bus.mouse_we = 0;

        // Clear sweep with a redundant clear_req mid-sweep.
        clear_req = 1; step(); clear_req = 0;
        for (int c = 0; c < DEPTH + 2; c++) begin
            clear_req = (c == 500);
            step();
        end
        clear_req = 0;
        check_canvas("t2_canvas");

        // Read session with ten dropped mouse writes.
        drop_pulses = 0;
        bus.rec_req = 1;
        for (int c = 0; c < DEPTH; c++) begin
            bus.rec_addr = ADDR_W'($urandom);
            bus.mouse_we = (c % 100 == 50);
            if (bus.mouse_we) drop_pulses++;
            step();
        end
        bus.mouse_we = 0;
        check("t3_drops", 32'(dropped_writes), 32'(drop_pulses));
        bus.rec_req = 0; step(); step();

        // Clear requested during a read waits for the session to end.
        bus.rec_req = 1;
        for (int c = 0; c < 50; c++) begin
            clear_req = (c == 10);
            bus.rec_addr = ADDR_W'($urandom);
            step();
        end
        clear_req = 0; bus.rec_req = 0;
        for (int c = 0; c < DEPTH + 3; c++) begin rand_mouse(); step(); end
        bus.mouse_we = 0;

        // Clear and read requested together: clear first, then read.
        clear_req = 1; bus.rec_req = 1; step(); clear_req = 0;
        for (int c = 0; c < DEPTH + 4; c++) begin bus.rec_addr = ADDR_W'($urandom); step(); end
        check("t5_grant", 32'(bus.rec_grant), 32'd1);
        bus.rec_req = 0; step();

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            rand_mouse();
            bus.rec_addr = ADDR_W'($urandom);
            if ($urandom_range(0, 39) == 0) bus.rec_req = ~bus.rec_req;
            clear_req = ($urandom_range(0, 299) == 0);
            step();
        end
        clear_req = 0; bus.rec_req = 0;
        for (int c = 0; c < DEPTH + 3; c++) begin rand_mouse(); step(); end
        check_canvas("rand_canvas");

        // Seed ones into the upper region, then reset partway through a sweep.
        for (int c = 0; c < 64; c++) begin
            bus.mouse_we = 1; bus.mouse_data = 1;
            bus.mouse_addr = ADDR_W'($urandom_range(300, DEPTH - 1));
            step();
        end
        clear_req = 1; bus.mouse_we = 0; step(); clear_req = 0;
        bus.mouse_we = 1;
        for (int c = 0; c < 300; c++) step();
        check("t6_sat", 32'(dropped_writes), 32'(DROP_MAX));
        rst = 1; #1;
        model_reset();
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_we", 32'(bus.ram_we), 32'(bus.mouse_we));
        check("t6_done", 32'(clear_done), 32'd0);
        bus.mouse_we = 0;
        step();
        rst = 0;
        for (int c = 0; c < 5; c++) step();
        check_canvas("t6_canvas");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
